uart_frame_timer: RTL and testbench

Parametrised bit-timing engine for the APB UART receiver. It generates per-bit sample and shift strobes for a full serial frame: start bit, 1..MAX_DATA data bits, optional parity bit, then 1 or 2 stop bits. It sits between the start-bit detector and the receive shift register and replaces the fixed two-counter timer. Over that timer it adds:
- run-time parity and stop-bit modes
- a mid-bit sample strobe
- field and bit-index reporting
- abort
- back-to-back frames
- config checking

---
 rtl/uart_frame_timer.sv | 194 +++++++++++++++++++
 tb/tb_uart_frame_timer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_timer.sv
// uart_frame_timer
// Bit-timing engine for the UART receiver. Once a start pulse is accepted it
// walks one serial frame: start bit, data bits, an optional parity bit, then
// one or two stop bits. For every bit it produces a mid-bit sample strobe and
// an end-of-bit shift strobe, and it reports the current field and data bit.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         one-cycle pulse from the start-bit detector
//   abort         kills the current frame
//   data_size     data bits per frame, legal 1..MAX_DATA
//   parity_en     one parity bit follows the data bits
//   two_stop      two stop bits instead of one
//   bit_period    clocks per bit, legal >= 2
//   sample_strobe mid-bit sample point of the current bit
//   shift_strobe  last cycle of the current bit
//   field         0 start, 1 data, 2 parity, 3 stop
//   bit_index     data bit number (LSB first), 0 outside the data field
//   packet_done   shift strobe of the final stop bit
//   busy          frame in progress
//   cfg_error     sticky flag: a start was rejected for an illegal config
module uart_frame_timer #(
    parameter int CNT_W    = 14,
    parameter int MAX_DATA = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [3:0]                  data_size,
    input  logic                        parity_en,
    input  logic                        two_stop,
    input  logic [CNT_W-1:0]            bit_period,
    output logic                        sample_strobe,
    output logic                        shift_strobe,
    output logic [1:0]                  field,
    output logic [$clog2(MAX_DATA)-1:0] bit_index,
    output logic                        packet_done,
    output logic                        busy,
    output logic                        cfg_error
);

    localparam int         IDX_W    = $clog2(MAX_DATA);
    localparam logic [3:0] MAX_SIZE = 4'(MAX_DATA);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic               stop_r, stop_s;     // 0 = first stop bit, 1 = second
    logic [3:0]         size_r, size_s;
    logic               par_r, par_s;
    logic               two_r, two_s;
    logic [CNT_W-1:0]   period_r, period_s;
    logic               cfg_err_s;
    logic               last_s;
    logic               done_s;
    logic               accept_s;
    logic               cfg_ok_s;
    logic [CNT_W-1:0]   half_s;

    // Next-state logic: abort beats everything, then start acceptance, then bit timing.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        stop_s    = stop_r;
        size_s    = size_r;
        par_s     = par_r;
        two_s     = two_r;
        period_s  = period_r;
        cfg_err_s = cfg_error;

        last_s   = (state_r != ST_IDLE) && (cnt_r == period_r);
        done_s   = last_s && (state_r == ST_STOP) && (stop_r == two_r);
        // A start landing on the final stop strobe chains straight into the next frame.
        accept_s = start && !abort && ((state_r == ST_IDLE) || done_s);
        cfg_ok_s = (bit_period >= CNT_W'(2)) && (data_size != 4'd0) && (data_size <= MAX_SIZE);

        if (abort && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            idx_s   = '0;
            stop_s  = 1'b0;
        end else if (accept_s) begin
            idx_s  = '0;
            stop_s = 1'b0;
            if (cfg_ok_s) begin
                state_s   = ST_START;
                cnt_s     = CNT_W'(1);
                size_s    = data_size;
                par_s     = parity_en;
                two_s     = two_stop;
                period_s  = bit_period;
                cfg_err_s = 1'b0;
            end else begin
                state_s   = ST_IDLE;
                cnt_s     = '0;
                cfg_err_s = 1'b1;
            end
        end else if (state_r == ST_IDLE) begin
            cnt_s = '0;
        end else if (last_s) begin
            cnt_s = CNT_W'(1);
            case (state_r)
                ST_START: begin
                    state_s = ST_DATA;
                    idx_s   = '0;
                end
                ST_DATA: begin
                    if (idx_r == IDX_W'(size_r - 4'd1)) begin
                        state_s = par_r ? ST_PARITY : ST_STOP;
                        idx_s   = '0;
                        stop_s  = 1'b0;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end
                ST_PARITY: begin
                    state_s = ST_STOP;
                    stop_s  = 1'b0;
                end
                ST_STOP: begin
                    if (stop_r == two_r) begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end else begin
                        stop_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end else begin
            cnt_s = cnt_r + CNT_W'(1);
        end

        half_s = period_s >> 1;
    end

    // State registers; outputs are registered decodes of the next state so they
    // line up with the state/counter values of the cycle in which they are seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            idx_r         <= '0;
            stop_r        <= 1'b0;
            size_r        <= 4'd0;
            par_r         <= 1'b0;
            two_r         <= 1'b0;
            period_r      <= '0;
            cfg_error     <= 1'b0;
            sample_strobe <= 1'b0;
            shift_strobe  <= 1'b0;
            field         <= 2'd0;
            bit_index     <= '0;
            packet_done   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            idx_r         <= idx_s;
            stop_r        <= stop_s;
            size_r        <= size_s;
            par_r         <= par_s;
            two_r         <= two_s;
            period_r      <= period_s;
            cfg_error     <= cfg_err_s;
            busy          <= (state_s != ST_IDLE);
            sample_strobe <= (state_s != ST_IDLE) && (cnt_s == half_s);
            shift_strobe  <= (state_s != ST_IDLE) && (cnt_s == period_s);
            packet_done   <= (state_s == ST_STOP) && (stop_s == two_s) && (cnt_s == period_s);
            bit_index     <= (state_s == ST_DATA) ? idx_s : '0;
            case (state_s)
                ST_DATA:   field <= 2'd1;
                ST_PARITY: field <= 2'd2;
                ST_STOP:   field <= 2'd3;
                default:   field <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_timer.sv
// Directed testbench for uart_frame_timer. Cycle numbering: the cycle in which
// start is driven is cycle 0; outputs of cycle c are sampled 1ns after the
// c-th following rising edge.
module tb_uart_frame_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  data_size;
    logic        parity_en;
    logic        two_stop;
    logic [13:0] bit_period;
    logic        sample_strobe;
    logic        shift_strobe;
    logic [1:0]  field;
    logic [3:0]  bit_index;
    logic        packet_done;
    logic        busy;
    logic        cfg_error;
    logic [9:0]  obs;

    int n_checks = 0;
    int n_errors = 0;

    uart_frame_timer #(.CNT_W(14), .MAX_DATA(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .data_size     (data_size),
        .parity_en     (parity_en),
        .two_stop      (two_stop),
        .bit_period    (bit_period),
        .sample_strobe (sample_strobe),
        .shift_strobe  (shift_strobe),
        .field         (field),
        .bit_index     (bit_index),
        .packet_done   (packet_done),
        .busy          (busy),
        .cfg_error     (cfg_error)
    );

    always #5 clk = ~clk;

    assign obs = {sample_strobe, shift_strobe, field, bit_index, packet_done, busy};

    // Expected output vector for cycle c of a frame started at cycle 0.
    function automatic logic [9:0] exp_vec(input int c, input int p, input int d,
                                           input int par, input int ts);
        int nb, n, pos;
        logic s, sh, dn;
        logic [1:0] f;
        logic [3:0] ix;
        nb = 2 + d + par + ts;
        if (c < 1 || c > nb * p) return 10'd0;
        n   = (c - 1) / p;
        pos = (c - 1) % p + 1;
        s   = (pos == p / 2);
        sh  = (pos == p);
        dn  = (c == nb * p);
        if (n == 0)                     f = 2'd0;
        else if (n <= d)                f = 2'd1;
        else if (par != 0 && n == d + 1) f = 2'd2;
        else                            f = 2'd3;
        ix = (f == 2'd1) ? 4'(n - 1) : 4'd0;
        return {s, sh, f, ix, dn, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic launch(input int p, input int d, input int par, input int ts);
        bit_period = 14'(p);
        data_size  = 4'(d);
        parity_en  = (par != 0);
        two_stop   = (ts != 0);
        start      = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        launch(10, 8, 0, 0);
        tick();
        tick();
        n_checks++;
        if (obs !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, 10'd0);
        end
        n_checks++;
        if (cfg_error !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_cfg_error got=%b exp=0", cfg_error);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_8n1();
        do_reset();
        launch(10, 8, 0, 0);
        for (int c = 1; c <= 102; c++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(c, 10, 8, 0, 0)) begin
                n_errors++;
                $display("FAIL 8n1 cycle=%0d got=%h exp=%h", c, obs, exp_vec(c, 10, 8, 0, 0));
            end
            if (c == 95 || c == 100) begin
                n_checks++;
                if (sample_strobe !== (c == 95) || shift_strobe !== (c == 100)) begin
                    n_errors++;
                    $display("FAIL 8n1_spot cycle=%0d got=%b%b", c, sample_strobe, shift_strobe);
                end
            end
        end
    endtask

    task automatic test_7e2();
        do_reset();
        launch(9, 7, 1, 1);
        for (int c = 1; c <= 101; c++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(c, 9, 7, 1, 1)) begin
                n_errors++;
                $display("FAIL 7e2 cycle=%0d got=%h exp=%h", c, obs, exp_vec(c, 9, 7, 1, 1));
            end
            if (c == 73 || c == 81 || c == 82 || c == 99) begin
                n_checks++;
                if (field !== ((c <= 81) ? 2'd2 : 2'd3) || packet_done !== (c == 99)) begin
                    n_errors++;
                    $display("FAIL 7e2_spot cycle=%0d field=%0d done=%b", c, field, packet_done);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] e;
        do_reset();
        launch(10, 8, 0, 0);
        for (int c = 1; c <= 60; c++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            e = (c <= 37) ? exp_vec(c, 10, 8, 0, 0) : 10'd0;
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL abort cycle=%0d got=%h exp=%h", c, obs, e);
            end
            if (c == 37) abort = 1'b1;
        end
        // start and abort together while idle: frame must not begin
        launch(10, 8, 0, 0);
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            n_checks++;
            if (obs !== 10'd0) begin
                n_errors++;
                $display("FAIL start_abort_idle cycle=%0d got=%h exp=%h", c, obs, 10'd0);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        do_reset();
        launch(10, 8, 0, 0);
        for (int c = 1; c <= 202; c++) begin
            tick();
            start = 1'b0;
            e = (c <= 100) ? exp_vec(c, 10, 8, 0, 0) : exp_vec(c - 100, 10, 8, 0, 0);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL back_to_back cycle=%0d got=%h exp=%h", c, obs, e);
            end
            if (c == 100) start = 1'b1;
        end
    endtask

    task automatic test_cfg_error();
        int bad_p [3] = '{1, 10, 10};
        int bad_d [3] = '{8, 0, 10};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            launch(bad_p[k], bad_d[k], 0, 0);
            tick();
            start = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                n_checks++;
                if (cfg_error !== 1'b1 || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL cfg_illegal_%0d cycle=%0d got err=%b busy=%b exp err=1 busy=0",
                             k, c, cfg_error, busy);
                end
                tick();
            end
        end
        // legal start clears the flag and runs a short frame: 3 bits of 4 clocks
        launch(4, 1, 0, 0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(c, 4, 1, 0, 0) || cfg_error !== 1'b0) begin
                n_errors++;
                $display("FAIL cfg_recover cycle=%0d got=%h err=%b exp=%h err=0",
                         c, obs, cfg_error, exp_vec(c, 4, 1, 0, 0));
            end
        end
        // reset also clears the sticky flag
        launch(10, 0, 0, 0);
        tick();
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (cfg_error !== 1'b0) begin
            n_errors++;
            $display("FAIL cfg_rst_clear got=%b exp=0", cfg_error);
        end
    endtask

    task automatic test_busy_ignore();
        do_reset();
        launch(10, 8, 0, 0);
        for (int c = 1; c <= 102; c++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(c, 10, 8, 0, 0)) begin
                n_errors++;
                $display("FAIL busy_ignore cycle=%0d got=%h exp=%h", c, obs, exp_vec(c, 10, 8, 0, 0));
            end
            if (c == 20) data_size = 4'd3;
            if (c == 30) start = 1'b1;
        end
        data_size = 4'd8;
    endtask

    task automatic test_mid_reset();
        do_reset();
        launch(10, 8, 0, 0);
        for (int c = 1; c <= 50; c++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(c, 10, 8, 0, 0)) begin
                n_errors++;
                $display("FAIL mid_reset_pre cycle=%0d got=%h exp=%h", c, obs, exp_vec(c, 10, 8, 0, 0));
            end
        end
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 51; c <= 55; c++) begin
            n_checks++;
            if (obs !== 10'd0 || cfg_error !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_reset cycle=%0d got=%h err=%b exp=%h err=0", c, obs, cfg_error, 10'd0);
            end
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        data_size  = 4'd8;
        parity_en  = 1'b0;
        two_stop   = 1'b0;
        bit_period = 14'd10;
        test_reset();
        test_8n1();
        test_7e2();
        test_abort();
        test_back_to_back();
        test_cfg_error();
        test_busy_ignore();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
